// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and types for the instruction prefetch unit
// Purpose: FSM state encodings, the NOOP word, the default reset PC and the
//          FIFO entry layout used by fetch_queue and its FIFO.
// Ports:   none (package).
package fetch_queue_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // sll $0,$0,0 - shown on instr whenever the queue is empty
    localparam logic [31:0] NOOP             = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory and decode handshake bundle of the prefetch unit
// Purpose: groups the instruction-memory req/ack bus, the decode valid/ready
//          bus and the redirect input.
// Ports:   master = fetch unit side, slave = memory/decode/branch side.
interface fetch_queue_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - DEPTH-entry {pc, instr} FIFO for the prefetch unit
// Purpose: buffers fetched words with their PCs; flush clears it in one cycle.
// Ports:   clk, rst (async active-low); push_i/push_data_i write; pop_i reads;
//          flush_i empties (overrides same-cycle push/pop); head_o, count_o,
//          empty_o, full_o status.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch unit between I-memory and decode
// Purpose: owns the fetch PC, issues sequential word fetches over req/ack,
//          buffers returned words in a FIFO drained by decode, and restarts
//          on redirect.
// Ports:   clk, rst (async active-low); bus (fetch_queue_if.master) carries
//          mem_req/mem_addr/mem_ack/mem_rdata, instr_valid/instr/instr_pc/
//          instr_ready and redirect/redirect_pc.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int             CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q;
    logic          push, pop;
    fetch_entry_t  push_data, head;
    logic [CW-1:0] count;
    logic          empty, full;
    logic          unused_rpc_bits;

    assign unused_rpc_bits = ^bus.redirect_pc[1:0];
    assign pop             = !empty && bus.instr_ready;
    assign push_data       = '{pc: req_addr_q, instr: bus.mem_rdata};

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (bus.redirect),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!full) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // Issue the next request only if a slot stays free after this push.
                    state_d    = (pop || count < LAST) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DISCARD: begin
                // fetch_pc_q already holds the redirect target; drop the stale word.
                if (bus.mem_ack) state_d = (pop || !full) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.redirect) begin
            push       = 1'b0;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            // An issued request cannot be withdrawn: wait out its ack in DISCARD.
            state_d    = (state_q != ST_IDLE && !bus.mem_ack) ? ST_DISCARD : ST_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            // Keep the stale address on the bus while discarding.
            if (state_d != ST_DISCARD) req_addr_q <= fetch_pc_d;
        end
    end

    assign bus.mem_req     = (state_q != ST_IDLE);
    assign bus.mem_addr    = req_addr_q;
    assign bus.instr_valid = !empty;
    assign bus.instr       = empty ? NOOP  : head.instr;
    assign bus.instr_pc    = empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    int   lat = 1;
    logic mem_en = 1'b1;
    int   wait_cnt = 0;
    int   ack_cnt = 0;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: ack after lat cycles of request (lat=1 is combinational).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 0;
            ack_cnt  <= 0;
        end else if (bus.mem_ack) begin
            wait_cnt <= 0;
            ack_cnt  <= ack_cnt + 1;
        end else if (bus.mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    assign bus.mem_ack   = bus.mem_req && mem_en && (wait_cnt >= lat - 1);
    assign bus.mem_rdata = bus.mem_addr ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        mem_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset values while held in reset
        @(negedge clk);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);

        // Zero-latency memory, decode always ready
        lat = 1;
        do_reset();
        @(negedge clk);
        chk("zl_req_c1", {31'b0, bus.mem_req}, 32'd1);
        chk("zl_addr_c1", bus.mem_addr, 32'h0);
        chk("zl_valid_c1", {31'b0, bus.instr_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("zl_addr", bus.mem_addr, 32'(4 * (i + 1)));
            chk("zl_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("zl_pc", bus.instr_pc, 32'(4 * i));
            chk("zl_instr", bus.instr, 32'(4 * i) ^ 32'hDEAD_0000);
        end

        // Decode stalled for 10 cycles: exactly four words fetched
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        chk("stall_req", {31'b0, bus.mem_req}, 32'd0);
        chk("stall_acks", 32'(ack_cnt), 32'd4);
        chk("stall_head_pc", bus.instr_pc, 32'h0);
        bus.instr_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("drain_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("drain_pc", bus.instr_pc, 32'(4 * i));
        end

        // Three-cycle memory latency
        lat = 3;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("lat_req", {31'b0, bus.mem_req}, 32'd1);
            chk("lat_addr", bus.mem_addr, 32'(4 * ((c - 1) / 3)));
            chk("lat_valid", {31'b0, bus.instr_valid}, (c >= 4 && (c - 4) % 3 == 0) ? 32'd1 : 32'd0);
            if (c >= 4 && (c - 4) % 3 == 0)
                chk("lat_pc", bus.instr_pc, 32'(4 * ((c - 4) / 3)));
        end

        // Redirect to 0x100 while the request for 0x10 is pending
        lat = 1;
        do_reset();
        repeat (5) @(negedge clk);
        chk("rd1_pre_addr", bus.mem_addr, 32'h10);
        mem_en = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("rd1_req", {31'b0, bus.mem_req}, 32'd1);
        chk("rd1_stale_addr", bus.mem_addr, 32'h10);
        chk("rd1_valid0", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        chk("rd1_stale_hold", bus.mem_addr, 32'h10);
        mem_en = 1'b1;
        @(negedge clk);
        chk("rd1_new_addr", bus.mem_addr, 32'h100);
        chk("rd1_dropped", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        chk("rd1_first_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("rd1_first_pc", bus.instr_pc, 32'h100);

        // Redirect to 0x203 with same-cycle ack and pop
        do_reset();
        repeat (3) @(negedge clk);
        chk("rd2_pre_pc", bus.instr_pc, 32'h4);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h203;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("rd2_empty", {31'b0, bus.instr_valid}, 32'd0);
        chk("rd2_addr", bus.mem_addr, 32'h200);
        chk("rd2_req", {31'b0, bus.mem_req}, 32'd1);
        @(negedge clk);
        chk("rd2_first_pc", bus.instr_pc, 32'h200);
        chk("rd2_next_addr", bus.mem_addr, 32'h204);

        // PC wrap from 0xFFFFFFFC
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("wrap_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr_zero", bus.mem_addr, 32'h0);
        chk("wrap_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr_top", bus.instr, 32'hFFFF_FFFC ^ 32'hDEAD_0000);
        @(negedge clk);
        chk("wrap_pc_zero", bus.instr_pc, 32'h0);

        // Asynchronous reset in the middle of a request
        chk("arst_pre_valid", {31'b0, bus.instr_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        chk("arst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("arst_instr", bus.instr, 32'h0);
        chk("arst_instr_pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
